mem_port_arbiter: RTL and testbench

//   Parametrised N-port memory front end between OBI-style core ports (instr, data, DMA/BFM) and one

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_port_arbiter_rr.sv | 38 +++
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: region config, permission bits, response slots.
// No logic; widths are fixed at their maxima (8 ports, 32-bit region addresses).
// Importers truncate or extend as needed.
package mem_arb_pkg;

   localparam int unsigned MaxIdW   = 3;
   localparam int unsigned RegAddrW = 32;

   // Bit positions inside a 2-bit permission field.
   typedef enum logic [0:0] {
      PERM_R = 1'b0,
      PERM_W = 1'b1
   } perm_e;

   typedef struct packed {
      logic [RegAddrW-1:0] base;
      logic [RegAddrW-1:0] limit;   // inclusive
      logic [1:0]          perm;    // indexed by perm_e
      logic                en;
   } region_cfg_t;

   typedef struct packed {
      logic              valid;
      logic [MaxIdW-1:0] id;
      logic              err;
   } resp_slot_t;

   // Width of a port index; a single port still needs one bit.
   function automatic int unsigned port_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin pick: first requester at or after the pointer, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the pick is used.
module rr_arbiter #(
   parameter int unsigned N   = 2,
   parameter int unsigned IdW = 1
) (
   input  logic [N-1:0]   req_i,
   input  logic [IdW-1:0] ptr_i,
   output logic [N-1:0]   gnt_o,
   output logic [IdW-1:0] idx_o,
   output logic           vld_o
);

   localparam int unsigned CW = IdW + 1;

   logic [CW-1:0] cand;

   // Scan ports starting at the pointer; the first one requesting wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = {1'b0, ptr_i} + CW'(i);
         if (cand >= CW'(N)) begin
            cand = cand - CW'(N);
         end
         if (!vld_o && req_i[cand[IdW-1:0]]) begin
            vld_o                = 1'b1;
            gnt_o[cand[IdW-1:0]] = 1'b1;
            idx_o                = cand[IdW-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port round-robin front end to one single-port RAM, with local range/protection errors.
// Grant same cycle as request; response exactly MemLatency cycles after grant, in grant order.
// No backpressure: one grant per cycle, the response pipeline can never fill.
// Optional region protection is compiled in with `define MEM_ARB_PROT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NumPorts   = 2,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned Depth      = 16384,
   parameter int unsigned MemLatency = 1,
   parameter int unsigned NumRegions = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NumPorts-1:0]                    req_i,
   output logic [NumPorts-1:0]                    gnt_o,
   input  logic [NumPorts-1:0]                    we_i,
   input  logic [NumPorts*(DataWidth/8)-1:0]      be_i,
   input  logic [NumPorts*AddrWidth-1:0]          addr_i,
   input  logic [NumPorts*DataWidth-1:0]          wdata_i,
   output logic [NumPorts-1:0]                    rvalid_o,
   output logic [NumPorts*DataWidth-1:0]          rdata_o,
   output logic [NumPorts-1:0]                    err_o,
   output logic                                   mem_req_o,
   output logic                                   mem_we_o,
   output logic [DataWidth/8-1:0]                 mem_be_o,
   output logic [$clog2(Depth)-1:0]               mem_addr_o,
   output logic [DataWidth-1:0]                   mem_wdata_o,
   input  logic                                   mem_rvalid_i,
   input  logic [DataWidth-1:0]                   mem_rdata_i,
   input  logic                                   cfg_we_i,
   input  logic [(NumRegions>1 ? $clog2(NumRegions) : 1)-1:0] cfg_idx_i,
   input  logic [AddrWidth-1:0]                   cfg_base_i,
   input  logic [AddrWidth-1:0]                   cfg_limit_i,
   input  logic [1:0]                             cfg_perm_i,
   output logic [15:0]                            viol_cnt_o
);

   localparam int unsigned BeW     = DataWidth / 8;
   localparam int unsigned OffW    = $clog2(BeW);
   localparam int unsigned PortIdW = port_id_w(NumPorts);
   localparam int unsigned MemAW   = $clog2(Depth);

   logic [PortIdW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NumPorts-1:0]  arb_gnt;
   logic [PortIdW-1:0]   win;
   logic                 any_req;
   logic                 grant;

   logic                 sel_we;
   logic [BeW-1:0]       sel_be;
   logic [AddrWidth-1:0] sel_addr;
   logic [AddrWidth-1:0] sel_word;
   logic [DataWidth-1:0] sel_wdata;
   logic                 range_err;
   logic                 prot_fault;
   logic                 access_err;

   resp_slot_t           pipe_q [MemLatency];
   resp_slot_t           slot_d;
   resp_slot_t           head;

   rr_arbiter #(
      .N   (NumPorts),
      .IdW (PortIdW)
   ) u_rr (
      .req_i (req_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (win),
      .vld_o (any_req)
   );

   // Nothing is granted while reset is held.
   assign grant = any_req & ~rst_i;
   assign gnt_o = grant ? arb_gnt : '0;

   // Pointer moves just past the winner, so idle ports never hold it up.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (win == PortIdW'(NumPorts - 1)) ? '0 : win + PortIdW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Mux the winning port's request fields.
   always_comb begin
      sel_we    = we_i[0];
      sel_be    = be_i[BeW-1:0];
      sel_addr  = addr_i[AddrWidth-1:0];
      sel_wdata = wdata_i[DataWidth-1:0];
      for (int unsigned p = 0; p < NumPorts; p++) begin
         if (win == PortIdW'(p)) begin
            sel_we    = we_i[p];
            sel_be    = be_i[p*BeW +: BeW];
            sel_addr  = addr_i[p*AddrWidth +: AddrWidth];
            sel_wdata = wdata_i[p*DataWidth +: DataWidth];
         end
      end
   end

   assign sel_word   = sel_addr >> OffW;
   assign range_err  = (sel_word >= AddrWidth'(Depth));
   assign access_err = range_err | prot_fault;

`ifdef MEM_ARB_PROT_EN
   region_cfg_t        regions_q [NumRegions];
   logic [15:0]        viol_cnt_q, viol_cnt_d;
   logic               region_hit;
   logic [RegAddrW-1:0] addr_ext;

   assign addr_ext = RegAddrW'(sel_addr);

   // Lowest-indexed enabled region containing the address decides; no match means allowed.
   always_comb begin
      prot_fault = 1'b0;
      region_hit = 1'b0;
      for (int unsigned r = 0; r < NumRegions; r++) begin
         if (!region_hit && regions_q[r].en &&
             addr_ext >= regions_q[r].base && addr_ext <= regions_q[r].limit) begin
            region_hit = 1'b1;
            prot_fault = sel_we ? ~regions_q[r].perm[PERM_W] : ~regions_q[r].perm[PERM_R];
         end
      end
   end

   // Saturating count of granted accesses rejected by protection.
   always_comb begin
      viol_cnt_d = viol_cnt_q;
      if (grant && prot_fault && viol_cnt_q != 16'hFFFF) begin
         viol_cnt_d = viol_cnt_q + 16'd1;
      end
   end

   // Region table and violation counter; a config write lands after this cycle's check.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned r = 0; r < NumRegions; r++) begin
            regions_q[r] <= '0;
         end
         viol_cnt_q <= '0;
      end else begin
         if (cfg_we_i) begin
            regions_q[cfg_idx_i] <= '{base:  RegAddrW'(cfg_base_i),
                                      limit: RegAddrW'(cfg_limit_i),
                                      perm:  cfg_perm_i,
                                      en:    1'b1};
         end
         viol_cnt_q <= viol_cnt_d;
      end
   end

   assign viol_cnt_o = viol_cnt_q;
`else
   logic unused_cfg;

   assign unused_cfg = ^{cfg_we_i, cfg_idx_i, cfg_base_i, cfg_limit_i, cfg_perm_i};
   assign prot_fault = 1'b0;
   assign viol_cnt_o = 16'h0000;
`endif

   // Rejected accesses are still granted but never reach the RAM.
   assign mem_req_o   = grant & ~access_err;
   assign mem_we_o    = sel_we;
   assign mem_be_o    = sel_be;
   assign mem_addr_o  = sel_word[MemAW-1:0];
   assign mem_wdata_o = sel_wdata;

   assign slot_d = '{valid: grant, id: MaxIdW'(win), err: access_err};
   assign head   = pipe_q[MemLatency-1];

   // Response tracker: one slot per RAM cycle, so ordering follows grant order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < MemLatency; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pipe_q[0] <= slot_d;
         for (int unsigned k = 1; k < MemLatency; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   // Route the head slot to its port; data only for good responses backed by the RAM.
   always_comb begin
      rvalid_o = '0;
      err_o    = '0;
      rdata_o  = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         if (head.valid && !rst_i && head.id == MaxIdW'(p)) begin
            rvalid_o[p] = 1'b1;
            err_o[p]    = head.err;
            if (!head.err && mem_rvalid_i) begin
               rdata_o[p*DataWidth +: DataWidth] = mem_rdata_i;
            end
         end
      end
   end

   // A RAM response with no live, non-error slot at the head means the RAM and tracker disagree.
   assert property (@(posedge clk_i) disable iff (rst_i)
                    mem_rvalid_i |-> (head.valid && !head.err));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PROT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Shared region config inputs
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_base, cfg_limit;
   logic [1:0]  cfg_perm;

   // DUT A: 2 ports, latency 1
   logic [1:0]  a_req, a_gnt, a_we, a_rvalid, a_err;
   logic [7:0]  a_be;
   logic [63:0] a_addr, a_wdata, a_rdata;
   logic        a_mem_req, a_mem_we, a_mem_rvalid;
   logic [3:0]  a_mem_be;
   logic [13:0] a_mem_addr;
   logic [31:0] a_mem_wdata, a_mem_rdata;
   logic [15:0] a_viol;

   // DUT B: 4 ports, latency 3
   logic [3:0]   b_req, b_gnt, b_we, b_rvalid, b_err;
   logic [15:0]  b_be;
   logic [127:0] b_addr, b_wdata, b_rdata;
   logic         b_mem_req, b_mem_we, b_mem_rvalid;
   logic [3:0]   b_mem_be;
   logic [13:0]  b_mem_addr;
   logic [31:0]  b_mem_wdata, b_mem_rdata;
   logic [15:0]  b_viol;

   logic [31:0] ram_a [16384];
   logic [31:0] ram_b [16384];

   mem_port_arbiter #(.NumPorts(2), .MemLatency(1)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we), .be_i(a_be),
      .addr_i(a_addr), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
      .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .mem_addr_o(a_mem_addr),
      .mem_wdata_o(a_mem_wdata), .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(a_mem_rdata),
      .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base), .cfg_limit_i(cfg_limit),
      .cfg_perm_i(cfg_perm), .viol_cnt_o(a_viol));

   mem_port_arbiter #(.NumPorts(4), .MemLatency(3)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we), .be_i(b_be),
      .addr_i(b_addr), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
      .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
      .mem_wdata_o(b_mem_wdata), .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata),
      .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_base_i(cfg_base), .cfg_limit_i(cfg_limit),
      .cfg_perm_i(cfg_perm), .viol_cnt_o(b_viol));

   // RAM model A: one-cycle latency, answers reads and writes; write responses carry zero data.
   always @(posedge clk) begin
      if (rst) begin
         a_mem_rvalid <= 1'b0;
         a_mem_rdata  <= '0;
      end else begin
         a_mem_rvalid <= a_mem_req;
         a_mem_rdata  <= (a_mem_req && !a_mem_we) ? ram_a[a_mem_addr] : 32'h0;
         if (a_mem_req && a_mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (a_mem_be[b]) ram_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // RAM model B: three-cycle latency.
   logic [2:0]  b_rv_q;
   logic [31:0] b_rd_q [3];
   always @(posedge clk) begin
      if (rst) begin
         b_rv_q <= '0;
         for (int i = 0; i < 3; i++) b_rd_q[i] <= '0;
      end else begin
         b_rv_q    <= {b_rv_q[1:0], b_mem_req};
         b_rd_q[0] <= (b_mem_req && !b_mem_we) ? ram_b[b_mem_addr] : 32'h0;
         b_rd_q[1] <= b_rd_q[0];
         b_rd_q[2] <= b_rd_q[1];
         if (b_mem_req && b_mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (b_mem_be[b]) ram_b[b_mem_addr][8*b +: 8] <= b_mem_wdata[8*b +: 8];
            end
         end
      end
   end
   assign b_mem_rvalid = b_rv_q[2];
   assign b_mem_rdata  = b_rd_q[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_port(input int p, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      a_req[p]             = req;
      a_we[p]              = we;
      a_be[p*4 +: 4]       = be;
      a_addr[p*32 +: 32]   = addr;
      a_wdata[p*32 +: 32]  = wdata;
   endtask

   task automatic test_reset();
      a_req = 2'b11;
      b_req = 4'hF;
      #1;
      checks++; if (a_gnt !== 2'b00) begin errors++; $display("FAIL rst_a_gnt got=%b exp=00", a_gnt); end
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rst_a_mem_req got=%b exp=0", a_mem_req); end
      checks++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL rst_a_rvalid got=%b exp=00", a_rvalid); end
      checks++; if (a_err !== 2'b00) begin errors++; $display("FAIL rst_a_err got=%b exp=00", a_err); end
      checks++; if (b_gnt !== 4'h0) begin errors++; $display("FAIL rst_b_gnt got=%b exp=0000", b_gnt); end
      checks++; if (a_viol !== 16'h0) begin errors++; $display("FAIL rst_viol got=%h exp=0000", a_viol); end
      tick();
      rst   = 1'b0;
      a_req = '0;
      b_req = '0;
   endtask

   // Two ports reading every cycle: strict alternation, each answered one cycle later.
   task automatic test_round_robin();
      logic [1:0]  eg, ev;
      logic [63:0] ed;
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
      a_port(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      for (int k = 0; k < 7; k++) begin
         if (k == 6) a_req = 2'b00;
         #1;
         eg = (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
         ev = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
         ed = (ev == 2'b01) ? {32'h0, 32'hA000_0000} : ((ev == 2'b10) ? {32'hA000_0001, 32'h0} : 64'h0);
         checks++; if (a_gnt !== eg) begin errors++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, a_gnt, eg); end
         checks++; if (a_rvalid !== ev) begin errors++; $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, a_rvalid, ev); end
         checks++; if (a_rdata !== ed) begin errors++; $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, a_rdata, ed); end
         if (k == 0) begin
            checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 14'd0) begin
               errors++; $display("FAIL rr_mem_req got=%b/%0d exp=1/0", a_mem_req, a_mem_addr); end
         end
         tick();
      end
   endtask

   // Port 0 reads the old word, port 1 writes the low half, port 0 reads the merged word.
   task automatic test_write_read();
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      a_port(1, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
      #1;
      checks++; if (a_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt0 got=%b exp=01", a_gnt); end
      checks++; if (a_mem_we !== 1'b0 || a_mem_addr !== 14'd16) begin
         errors++; $display("FAIL wr_rd_req got=we%b/%0d exp=we0/16", a_mem_we, a_mem_addr); end
      tick();
      #1;
      checks++; if (a_gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt1 got=%b exp=10", a_gnt); end
      checks++; if (a_mem_we !== 1'b1 || a_mem_be !== 4'b0011 || a_mem_wdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL wr_wr_req got=we%b be%b %h exp=we1 be0011 deadbeef", a_mem_we, a_mem_be, a_mem_wdata); end
      checks++; if (a_rvalid !== 2'b01 || a_rdata !== 64'h0) begin
         errors++; $display("FAIL wr_old_word got=%b %h exp=01 0", a_rvalid, a_rdata); end
      tick();
      a_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      checks++; if (a_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt2 got=%b exp=01", a_gnt); end
      checks++; if (a_rvalid !== 2'b10 || a_err !== 2'b00 || a_rdata !== 64'h0) begin
         errors++; $display("FAIL wr_wresp got=%b %b %h exp=10 00 0", a_rvalid, a_err, a_rdata); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_rvalid !== 2'b01 || a_rdata !== {32'h0, 32'h0000_BEEF}) begin
         errors++; $display("FAIL wr_merged got=%b %h exp=01 0000beef", a_rvalid, a_rdata); end
      tick();
   endtask

   // First word past the RAM errors locally; the last word inside is a normal access.
   task automatic test_range();
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
      #1;
      checks++; if (a_gnt !== 2'b01) begin errors++; $display("FAIL rng_gnt got=%b exp=01", a_gnt); end
      checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rng_mem_req got=%b exp=0", a_mem_req); end
      tick();
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0);
      #1;
      checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 14'h3FFF) begin
         errors++; $display("FAIL rng_last got=%b/%h exp=1/3fff", a_mem_req, a_mem_addr); end
      checks++; if (a_rvalid !== 2'b01 || a_err !== 2'b01 || a_rdata !== 64'h0) begin
         errors++; $display("FAIL rng_err_resp got=%b %b %h exp=01 01 0", a_rvalid, a_err, a_rdata); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_rvalid !== 2'b01 || a_err !== 2'b00) begin
         errors++; $display("FAIL rng_ok_resp got=%b %b exp=01 00", a_rvalid, a_err); end
      tick();
   endtask

   // Read-only region blocks writes (when built in); config written alongside an access applies later.
   task automatic test_protection();
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = 32'h100; cfg_limit = 32'h1FF; cfg_perm = 2'b01;
      tick();
      cfg_we = 1'b0;
      a_port(0, 1'b1, 1'b1, 4'hF, 32'h104, 32'h1234_5678);
      #1;
      checks++; if (a_mem_req !== !PROT) begin errors++; $display("FAIL prot_wr_req got=%b exp=%b", a_mem_req, !PROT); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_rvalid !== 2'b01 || a_err !== {1'b0, PROT}) begin
         errors++; $display("FAIL prot_wr_resp got=%b %b exp=01 0%b", a_rvalid, a_err, PROT); end
      checks++; if (a_viol !== (PROT ? 16'd1 : 16'd0)) begin
         errors++; $display("FAIL prot_viol1 got=%0d exp=%0d", a_viol, PROT ? 1 : 0); end
      tick();
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
      #1;
      checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL prot_rd_req got=%b exp=1", a_mem_req); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_rvalid !== 2'b01 || a_err !== 2'b00 || a_rdata !== {32'h0, (PROT ? 32'h0 : 32'h1234_5678)}) begin
         errors++; $display("FAIL prot_rd_resp got=%b %b %h exp=01 00 %h", a_rvalid, a_err, a_rdata, PROT ? 32'h0 : 32'h1234_5678); end
      tick();
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_base = 32'h300; cfg_limit = 32'h3FF; cfg_perm = 2'b00;
      a_port(0, 1'b1, 1'b1, 4'hF, 32'h300, 32'hCAFE_0000);
      #1;
      checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL prot_same_cycle got=%b exp=1", a_mem_req); end
      tick();
      cfg_we = 1'b0;
      #1;
      checks++; if (a_mem_req !== !PROT) begin errors++; $display("FAIL prot_new_region got=%b exp=%b", a_mem_req, !PROT); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_err !== {1'b0, PROT} || a_viol !== (PROT ? 16'd2 : 16'd0)) begin
         errors++; $display("FAIL prot_viol2 got=%b %0d exp=0%b %0d", a_err, a_viol, PROT, PROT ? 2 : 0); end
      tick();
   endtask

   // Four ports, latency 3: grants 0..3 in turn, responses three cycles behind each.
   task automatic test_latency3();
      logic [3:0]   eg, ev;
      logic [127:0] ed;
      for (int p = 0; p < 4; p++) begin
         b_addr[p*32 +: 32] = 32'(4 * p);
      end
      b_req = 4'hF;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) b_req = 4'h0;
         #1;
         eg = (k < 4) ? 4'(1 << k) : 4'h0;
         ev = (k >= 3 && k <= 6) ? 4'(1 << (k - 3)) : 4'h0;
         ed = '0;
         if (k >= 3 && k <= 6) ed[(k-3)*32 +: 32] = 32'hB000_0000 + 32'(k - 3);
         checks++; if (b_gnt !== eg) begin errors++; $display("FAIL lat_gnt k=%0d got=%b exp=%b", k, b_gnt, eg); end
         checks++; if (b_rvalid !== ev) begin errors++; $display("FAIL lat_rvalid k=%0d got=%b exp=%b", k, b_rvalid, ev); end
         checks++; if (b_rdata !== ed) begin errors++; $display("FAIL lat_rdata k=%0d got=%h exp=%h", k, b_rdata, ed); end
         tick();
      end
   endtask

   // Reset the cycle after a grant: response dropped, pointer back to port 0.
   task automatic test_reset_mid();
      a_port(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
      a_port(1, 1'b0, 1'b0, 4'hF, 32'h4, 32'h0);
      b_addr[31:0] = 32'h0;
      b_req = 4'b0001;
      #1;
      checks++; if (a_gnt !== 2'b01 || b_gnt !== 4'b0001) begin
         errors++; $display("FAIL rm_pre_gnt got=%b %b exp=01 0001", a_gnt, b_gnt); end
      tick();
      rst   = 1'b1;
      a_req = 2'b11;
      b_req = 4'h0;
      #1;
      checks++; if (a_gnt !== 2'b00 || a_rvalid !== 2'b00 || a_mem_req !== 1'b0) begin
         errors++; $display("FAIL rm_in_rst got=%b %b %b exp=00 00 0", a_gnt, a_rvalid, a_mem_req); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (a_gnt !== 2'b01) begin errors++; $display("FAIL rm_ptr got=%b exp=01", a_gnt); end
      checks++; if (a_rvalid !== 2'b00 || b_rvalid !== 4'h0) begin
         errors++; $display("FAIL rm_flush0 got=%b %b exp=00 0000", a_rvalid, b_rvalid); end
      tick();
      a_req = 2'b00;
      #1;
      checks++; if (a_rvalid !== 2'b01 || a_rdata !== {32'h0, 32'hA000_0000}) begin
         errors++; $display("FAIL rm_after got=%b %h exp=01 a0000000", a_rvalid, a_rdata); end
      checks++; if (b_rvalid !== 4'h0) begin errors++; $display("FAIL rm_flush1 got=%b exp=0000", b_rvalid); end
      tick();
      #1;
      checks++; if (b_rvalid !== 4'h0) begin errors++; $display("FAIL rm_flush2 got=%b exp=0000", b_rvalid); end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_limit = '0; cfg_perm = '0;
      a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
      b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 16384; i++) begin
         ram_a[i] <= (i < 16) ? 32'hA000_0000 + 32'(i) : 32'h0;
         ram_b[i] <= (i < 4)  ? 32'hB000_0000 + 32'(i) : 32'h0;
      end
      tick();
      tick();
      test_reset();
      test_round_robin();
      test_write_read();
      test_range();
      test_protection();
      test_latency3();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
